// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, FSM states and latency constants for seq_calc_core
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ABS = 3'b010,
    OP_NEG = 3'b011,
    OP_MUL = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Start-to-done edges for the single-cycle operations
  localparam int ALU_LAT = 2;

  // Start-to-done edges for MUL: accept, WIDTH shift-add steps, then the result edge
  function automatic int mul_lat(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/seq_mul_shift_add.sv
// rtl/seq_mul_shift_add.sv - unsigned WIDTH x WIDTH iterative shift-add multiplier
module seq_mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 finished
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // One multiplier bit per step: add the shifted multiplicand when the current bit is set
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step && !finished) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  assign product  = acc_q;
  assign finished = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/seq_calc_core.sv
// rtl/seq_calc_core.sv - clocked signed add/sub/abs/neg/mul calculator with overflow flags
module seq_calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_flags,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             err
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic               accept;
  logic               load_result;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] ea, eb, exact;
  logic [WIDTH:0]     exact_hi;
  logic               ovf_d;
  logic [WIDTH-1:0]   res_d;

  assign accept      = (state_q == S_IDLE) && start;
  assign load_result = (state_q == S_EXEC) || ((state_q == S_MULT) && mul_fin);

  // The multiplier works on magnitudes taken straight from the inputs so it can load on the accept edge
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  seq_mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk      (CLOCK_50),
    .reset    (reset),
    .load     (accept),
    .step     (state_q == S_MULT),
    .mcand    (mag_a),
    .mplier   (mag_b),
    .product  (mul_prod),
    .finished (mul_fin)
  );

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (op == OP_MUL) ? S_MULT : S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_MULT: begin
        busy = 1'b1;
        if (mul_fin) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Exact value in 2*WIDTH bits for every op, then range check against WIDTH bits
  always_comb begin
    ea    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    eb    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    exact = '0;
    case (op_q)
      OP_ADD:  exact = ea + eb;
      OP_SUB:  exact = ea - eb;
      OP_ABS:  exact = a_q[WIDTH-1] ? -ea : ea;
      OP_NEG:  exact = -ea;
      OP_MUL:  exact = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mul_prod : mul_prod;
      default: exact = '0;
    endcase
    exact_hi = exact[2*WIDTH-1:WIDTH-1];
    ovf_d    = !((exact_hi == '0) || (exact_hi == '1));
    if (ovf_d && SATURATE) begin
      res_d = exact[2*WIDTH-1] ? SMIN : SMAX;
    end else begin
      res_d = exact[WIDTH-1:0];
    end
  end

  // Operand latch, registered result and sticky flags; a flag set wins over a same-edge clear
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (load_result) begin
        result <= res_d;
        ovf    <= ovf_d;
      end
      if (load_result && ovf_d) begin
        ovf_sticky <= 1'b1;
      end else if (clr_flags) begin
        ovf_sticky <= 1'b0;
      end
      if (accept && (op > 3'd4)) begin
        err <= 1'b1;
      end else if (clr_flags) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_calc_core.sv
// tb/tb_seq_calc_core.sv - scoreboard bench driving WIDTH=8, WIDTH=8 saturating and WIDTH=4 cores in parallel
module tb_seq_calc_core;

  typedef struct {
    int res;
    bit ovf;
    bit stk;
    bit err;
    int lat;
    int t0;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        st;
  logic [2:0]        op;
  logic [7:0]        a, b;
  logic              clr;
  logic [2:0]        busy_v, done_v, ovf_v, stk_v, err_v;
  logic signed [7:0] r8, r8s;
  logic signed [3:0] r4;
  int                rv[3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[3][$];
  bit   stk_m[3];
  bit   err_m[3];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_calc_core #(.WIDTH(8), .SATURATE(1'b0)) u_w8 (
    .CLOCK_50(clk), .reset(reset), .start(st[0]), .op(op), .a(a), .b(b), .clr_flags(clr),
    .busy(busy_v[0]), .done(done_v[0]), .result(r8), .ovf(ovf_v[0]), .ovf_sticky(stk_v[0]), .err(err_v[0]));

  seq_calc_core #(.WIDTH(8), .SATURATE(1'b1)) u_w8s (
    .CLOCK_50(clk), .reset(reset), .start(st[1]), .op(op), .a(a), .b(b), .clr_flags(clr),
    .busy(busy_v[1]), .done(done_v[1]), .result(r8s), .ovf(ovf_v[1]), .ovf_sticky(stk_v[1]), .err(err_v[1]));

  seq_calc_core #(.WIDTH(4), .SATURATE(1'b0)) u_w4 (
    .CLOCK_50(clk), .reset(reset), .start(st[2]), .op(op), .a(a[3:0]), .b(b[3:0]), .clr_flags(clr),
    .busy(busy_v[2]), .done(done_v[2]), .result(r4), .ovf(ovf_v[2]), .ovf_sticky(stk_v[2]), .err(err_v[2]));

  always_comb begin
    rv[0] = int'(r8);
    rv[1] = int'(r8s);
    rv[2] = int'(r4);
  end

  function automatic int wid(input int i);
    return (i == 2) ? 4 : 8;
  endfunction

  function automatic bit sat(input int i);
    return (i == 1);
  endfunction

  // Reinterpret the low w bits of v as a signed number
  function automatic int tr(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  // Reference: exact integer arithmetic, then range check, wrap or clamp
  function automatic exp_t model(input int o, input int x, input int y, input int w, input bit s);
    exp_t e;
    int   v, lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    case (o)
      0:       v = x + y;
      1:       v = x - y;
      2:       v = (x < 0) ? -x : x;
      3:       v = -x;
      4:       v = x * y;
      default: v = 0;
    endcase
    e.ovf = (v < lo) || (v > hi);
    if (!e.ovf)  e.res = v;
    else if (s)  e.res = (v > hi) ? hi : lo;
    else         e.res = tr(v, w);
    e.stk = 1'b0;
    e.err = 1'b0;
    e.lat = 0;
    e.t0  = 0;
    return e;
  endfunction

  task automatic check(input string nm, input int i, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, i, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation for that core
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && done_v[i]) begin
        if (sb[i].size() == 0) begin
          check("unexpected_done", i, 1, 0);
        end else begin
          mon_e = sb[i].pop_front();
          check("result", i, rv[i], mon_e.res);
          check("ovf", i, int'(ovf_v[i]), int'(mon_e.ovf));
          check("ovf_sticky", i, int'(stk_v[i]), int'(mon_e.stk));
          check("err", i, int'(err_v[i]), int'(mon_e.err));
          check("latency", i, cyc - mon_e.t0, mon_e.lat);
        end
      end
    end
  end

  task automatic push_exp(input int o, input int av, input int bv, input bit clr_same);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(o, tr(av, wid(i)), tr(bv, wid(i)), wid(i), sat(i));
      if (clr_same) begin
        stk_m[i] = 1'b0;
        err_m[i] = 1'b0;
      end
      if (e.ovf) stk_m[i] = 1'b1;
      if (o > 4) err_m[i] = 1'b1;
      e.stk = stk_m[i];
      e.err = err_m[i];
      e.lat = (o == 4) ? wid(i) + 2 : 2;
      e.t0  = cyc;
      sb[i].push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 0, int'(n >= 40), 0);
    for (int i = 0; i < 3; i++) sb[i].delete();
  endtask

  task automatic issue(input int o, input int av, input int bv, input bit clr_same);
    @(negedge clk);
    op = 3'(o);
    a  = 8'(av);
    b  = 8'(bv);
    st = 3'b111;
    push_exp(o, av, bv, clr_same);
    @(negedge clk);
    st = 3'b000;
    for (int i = 0; i < 3; i++) check("busy", i, int'(busy_v[i]), 1);
    if (clr_same) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    wait_drain();
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stk_m[i] = 1'b0;
      err_m[i] = 1'b0;
      check("clr_sticky", i, int'(stk_v[i]), 0);
      check("clr_err", i, int'(err_v[i]), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_busy"}, i, int'(busy_v[i]), 0);
      check({tag, "_done"}, i, int'(done_v[i]), 0);
      check({tag, "_result"}, i, rv[i], 0);
      check({tag, "_ovf"}, i, int'(ovf_v[i]), 0);
      check({tag, "_sticky"}, i, int'(stk_v[i]), 0);
      check({tag, "_err"}, i, int'(err_v[i]), 0);
    end
  endtask

  // Keep start high on every cycle of a MUL until each core shows its done pulse
  task automatic hammer(input int av, input int bv);
    bit [2:0] fin;
    int n;
    @(negedge clk);
    op = 3'd4;
    a  = 8'(av);
    b  = 8'(bv);
    st = 3'b111;
    push_exp(4, av, bv, 1'b0);
    fin = '0;
    n   = 0;
    while (fin != 3'b111 && n < 40) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          fin[i] = 1'b1;
          st[i]  = 1'b0;
        end else if (!fin[i]) begin
          st[i] = 1'b1;
        end
      end
      n++;
    end
    st = 3'b000;
    wait_drain();
    repeat (4) @(negedge clk);
  endtask

  // Reset during the 4th MUL cycle: no done may follow and every output is zero
  task automatic reset_mid_mul();
    @(negedge clk);
    op = 3'd4;
    a  = 8'(-12);
    b  = 8'(10);
    st = 3'b111;
    @(negedge clk);
    st = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stk_m[i] = 1'b0;
      err_m[i] = 1'b0;
    end
    check_zero("mid_reset");
    repeat (14) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o, av, bv;
    reset = 1'b1;
    st    = 3'b000;
    clr   = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    for (int i = 0; i < 3; i++) begin
      stk_m[i] = 1'b0;
      err_m[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(0, 100, 27, 1'b0);
    issue(0, 100, 28, 1'b0);
    issue(1, -100, 29, 1'b0);
    issue(1, 5, 5, 1'b0);
    clear_flags();
    issue(2, -128, 0, 1'b0);
    issue(2, -7, 0, 1'b0);
    issue(3, 0, 0, 1'b0);
    issue(3, -128, 0, 1'b0);
    issue(4, -12, 10, 1'b0);
    issue(4, 16, 16, 1'b0);
    issue(6, 3, 4, 1'b0);
    issue(0, 7, 1, 1'b0);
    issue(4, -8, -8, 1'b0);
    issue(4, 7, -2, 1'b0);
    issue(4, -128, -128, 1'b0);
    issue(0, 100, 28, 1'b1);
    hammer(-12, 10);
    issue(7, 1, 1, 1'b0);
    issue(0, 100, 28, 1'b0);
    reset_mid_mul();

    for (int k = 0; k < 60; k++) begin
      o = int'($urandom_range(0, 9));
      if (o > 7) o = 4;
      av = int'($urandom_range(0, 255)) - 128;
      bv = int'($urandom_range(0, 255)) - 128;
      issue(o, av, bv, 1'b0);
      if ($urandom_range(0, 7) == 0) clear_flags();
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
